// File: rtl/rr_port_scheduler_if.sv
// Handshake bundle between the packet sources and the round-robin write-path scheduler.
// The master side drives requests and beats; the scheduler (slave) returns grant and status.
interface rr_port_scheduler_if #(
  parameter int PORTNUM = 16,
  parameter int MAXBEAT = 32
);
  localparam int SEL_W = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int LEN_W = $clog2(MAXBEAT) + 1;

  logic [PORTNUM-1:0] i_req;
  logic               i_dst_ready;
  logic               i_vld;
  logic               i_eop;
  logic               o_port_ready;
  logic [PORTNUM-1:0] o_grant;
  logic [SEL_W-1:0]   o_sel;
  logic               o_done;
  logic               o_abort;
  logic [LEN_W-1:0]   o_len;

  modport master (
    output i_req, i_dst_ready, i_vld, i_eop,
    input  o_port_ready, o_grant, o_sel, o_done, o_abort, o_len
  );

  modport slave (
    input  i_req, i_dst_ready, i_vld, i_eop,
    output o_port_ready, o_grant, o_sel, o_done, o_abort, o_len
  );
endinterface

// File: rtl/rr_port_scheduler.sv
// Round-robin scheduler granting one input port at a time the cache write path for a whole
// packet, ending it on eop, on an idle timeout, or when the packet grows past MAXBEAT beats.
module rr_port_scheduler #(
  parameter int PORTNUM = 16,
  parameter int TIMEOUT = 64,
  parameter int MAXBEAT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rr_port_scheduler_if.slave   bus
);
  localparam int SEL_W  = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int LEN_W  = $clog2(MAXBEAT) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t             state_q,    state_d;
  logic [PORTNUM-1:0] grant_q,    grant_d;
  logic [SEL_W-1:0]   sel_q,      sel_d;
  logic [SEL_W-1:0]   last_sel_q, last_sel_d;
  logic               done_q,     done_d;
  logic               abort_q,    abort_d;
  logic [LEN_W-1:0]   len_q,      len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [SEL_W-1:0]   pick;
  logic               pkt_end;

  // First requesting port strictly after 'last', wrapping past PORTNUM-1 to 0.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [PORTNUM-1:0] req,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0]   sel;
    logic [PORTNUM-1:0] sh;
    logic               found;
    int                 idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTNUM; k++) begin
      idx = (int'(last) + k) % PORTNUM;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        sel   = SEL_W'(idx);
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(bus.i_req, last_sel_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_sel_d = last_sel_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    pkt_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((bus.i_req != '0) && bus.i_dst_ready) begin
          state_d       = S_XFER;
          sel_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          beat_cnt_d    = '0;
          idle_cnt_d    = '0;
        end
      end
      S_XFER: begin
        if (bus.i_vld) begin
          idle_cnt_d = '0;
          // A beat beyond MAXBEAT aborts even when it carries eop; an eop exactly at MAXBEAT completes.
          if (beat_cnt_q == LEN_W'(MAXBEAT)) begin
            pkt_end = 1'b1;
            abort_d = 1'b1;
            len_d   = LEN_W'(MAXBEAT);
          end else if (bus.i_eop) begin
            pkt_end = 1'b1;
            done_d  = 1'b1;
            len_d   = beat_cnt_q + LEN_W'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
          pkt_end = 1'b1;
          abort_d = 1'b1;
          len_d   = beat_cnt_q;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end

        if (pkt_end) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          last_sel_d = sel_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_sel_q <= SEL_W'(PORTNUM - 1);
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      last_sel_q <= last_sel_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Ready is forced high while reset is held so sources never see a stale XFER state.
  assign bus.o_port_ready = (state_q == S_IDLE) || !i_rst_n;
  assign bus.o_grant      = grant_q;
  assign bus.o_sel        = sel_q;
  assign bus.o_done       = done_q;
  assign bus.o_abort      = abort_q;
  assign bus.o_len        = len_q;
endmodule

// File: tb/tb_rr_port_scheduler.sv
// Bench for rr_port_scheduler: vector table, directed corner sequences, and randomized
// packets checked against a transaction-level round-robin model.
module tb_rr_port_scheduler;
  localparam int PN = 16;
  localparam int TO = 64;
  localparam int MB = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   mlast;

  rr_port_scheduler_if #(.PORTNUM(PN), .MAXBEAT(MB)) bus ();
  rr_port_scheduler #(.PORTNUM(PN), .TIMEOUT(TO), .MAXBEAT(MB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] req;
    int          nbeats;
    bit          eop;
    int          exp_sel;
    bit          exp_done;
    int          exp_len;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("done_abort_exclusive", 32'(bus.o_done & bus.o_abort), 32'd0);
  endtask

  // Reference arbitration: first requesting port after 'last', modulo the port count.
  function automatic int model_pick(input logic [15:0] req, input int last);
    logic [15:0] sh;
    for (int k = 1; k <= PN; k++) begin
      sh = req >> ((last + k) % PN);
      if (sh[0]) return (last + k) % PN;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = '0; bus.i_vld = 1'b0; bus.i_eop = 1'b0; bus.i_dst_ready = 1'b1;
    tick();
    chk("rst_ready_during", 32'(bus.o_port_ready), 32'd1);
    tick();
    chk("rst_grant", 32'(bus.o_grant), 32'd0);
    chk("rst_sel", 32'(bus.o_sel), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_abort", 32'(bus.o_abort), 32'd0);
    chk("rst_len", 32'(bus.o_len), 32'd0);
    rst_n = 1'b1;
    mlast = PN - 1;
    tick();
    chk("rst_ready_after", 32'(bus.o_port_ready), 32'd1);
  endtask

  task automatic wait_grant(input bit rnd, output int port, output bit ok);
    logic [15:0] sh;
    ok = 1'b0;
    port = -1;
    for (int i = 0; i < 200; i++) begin
      bus.i_dst_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_vld = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_eop = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (i == 0) chk("pulse_one_cycle", 32'({bus.o_done, bus.o_abort}), 32'd0);
      if (bus.o_grant != '0) begin
        for (int p = 0; p < PN; p++) begin
          sh = bus.o_grant >> p;
          if (sh[0]) port = p;
        end
        chk("grant_onehot", 32'($countones(bus.o_grant)), 32'd1);
        chk("sel_matches_grant", 32'(bus.o_sel), 32'(port));
        chk("ready_low_in_xfer", 32'(bus.o_port_ready), 32'd0);
        ok = 1'b1;
        break;
      end
      chk("ready_high_idle", 32'(bus.o_port_ready), 32'd1);
    end
    if (!ok) chk("grant_wait_bound", 32'd0, 32'd1);
  endtask

  // Grant, one cycle of source latency, then beats with 'gap' idle cycles between them.
  task automatic xact(input logic [15:0] req, input int nbeats, input bit eop, input int gap,
                      input bit rnd, output int port, output bit gd, output bit ga,
                      output int len, output int sent, output int wc);
    bit          ok;
    bit          ended;
    logic [15:0] g0;
    gd = 0; ga = 0; len = -1; sent = 0; wc = 0; ended = 0;
    bus.i_req = req;
    wait_grant(rnd, port, ok);
    if (!ok) return;
    g0 = bus.o_grant;
    bus.i_vld = 1'b0; bus.i_eop = 1'b0;
    tick();
    chk("grant_held_latency", 32'(bus.o_grant), 32'(g0));
    for (int b = 1; b <= nbeats; b++) begin
      if (b > 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.i_vld = 1'b0; bus.i_eop = 1'($urandom_range(0, 1));
          tick();
          chk("grant_held_gap", 32'(bus.o_grant), 32'(g0));
        end
      end
      bus.i_vld = 1'b1;
      bus.i_eop = eop && (b == nbeats);
      if (rnd) bus.i_req = 16'($urandom());
      tick();
      sent = b;
      if (bus.o_done || bus.o_abort) begin
        gd = bus.o_done; ga = bus.o_abort; len = int'(bus.o_len); ended = 1;
        chk("grant_cleared_at_end", 32'(bus.o_grant), 32'd0);
        break;
      end
      chk("grant_held_beat", 32'(bus.o_grant), 32'(g0));
    end
    bus.i_vld = 1'b0; bus.i_eop = 1'b0;
    if (!ended) begin
      for (int k = 1; k <= TO + 10; k++) begin
        tick();
        if (bus.o_done || bus.o_abort) begin
          gd = bus.o_done; ga = bus.o_abort; len = int'(bus.o_len); wc = k; ended = 1;
          chk("grant_cleared_at_end", 32'(bus.o_grant), 32'd0);
          break;
        end
      end
      if (!ended) chk("packet_end_bound", 32'd0, 32'd1);
    end
  endtask

  // Packet checked against the model: arbitration from mlast, outcome from length/eop rules.
  task automatic model_pkt(input string tag, input logic [15:0] req, input int nbeats,
                           input bit eop, input int gap, input bit rnd);
    int port, len, sent, wc, exp_port;
    bit gd, ga;
    exp_port = model_pick(req, mlast);
    xact(req, nbeats, eop, gap, rnd, port, gd, ga, len, sent, wc);
    chk({tag, "_port"}, 32'(port), 32'(exp_port));
    if (nbeats > MB) begin
      chk({tag, "_ovl_abort"}, 32'({gd, ga}), 32'b01);
      chk({tag, "_ovl_len"}, 32'(len), 32'(MB));
      chk({tag, "_ovl_beat"}, 32'(sent), 32'(MB + 1));
    end else if (eop) begin
      chk({tag, "_done"}, 32'({gd, ga}), 32'b10);
      chk({tag, "_len"}, 32'(len), 32'(nbeats));
    end else begin
      chk({tag, "_to_abort"}, 32'({gd, ga}), 32'b01);
      chk({tag, "_to_len"}, 32'(len), 32'(nbeats));
      chk({tag, "_to_delay"}, 32'(wc), 32'(TO));
    end
    mlast = exp_port;
  endtask

  initial begin
    vec_t tbl[10];
    int   port, len, sent, wc, gcyc, prev_gcyc;
    bit   gd, ga, ok;

    tbl[0] = '{16'hFFFF,  1, 1'b1,  0, 1'b1,  1};
    tbl[1] = '{16'hFFFF,  1, 1'b1,  1, 1'b1,  1};
    tbl[2] = '{16'h0009,  2, 1'b1,  3, 1'b1,  2};
    tbl[3] = '{16'h0009,  1, 1'b1,  0, 1'b1,  1};
    tbl[4] = '{16'h8001,  4, 1'b1, 15, 1'b1,  4};
    tbl[5] = '{16'h8001,  1, 1'b1,  0, 1'b1,  1};
    tbl[6] = '{16'h0100, 32, 1'b1,  8, 1'b1, 32};
    tbl[7] = '{16'h0100, 33, 1'b1,  8, 1'b0, 32};
    tbl[8] = '{16'h0004,  3, 1'b0,  2, 1'b0,  3};
    tbl[9] = '{16'h0006,  1, 1'b1,  1, 1'b1,  1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      xact(tbl[i].req, tbl[i].nbeats, tbl[i].eop, 0, 1'b0, port, gd, ga, len, sent, wc);
      chk($sformatf("tbl%0d_sel", i), 32'(port), 32'(tbl[i].exp_sel));
      chk($sformatf("tbl%0d_done", i), 32'(gd), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_abort", i), 32'(ga), 32'(!tbl[i].exp_done));
      chk($sformatf("tbl%0d_len", i), 32'(len), 32'(tbl[i].exp_len));
    end

    // Rotation with all ports requesting: 0..15 then 0, one grant every 3 cycles.
    do_reset();
    prev_gcyc = 0;
    for (int i = 0; i < 17; i++) begin
      bus.i_req = 16'hFFFF;
      wait_grant(1'b0, port, ok);
      gcyc = cyc;
      chk("rot_order", 32'(port), 32'(i % PN));
      if (i > 0) chk("rot_period", 32'(gcyc - prev_gcyc), 32'd3);
      prev_gcyc = gcyc;
      bus.i_vld = 1'b0; tick();
      bus.i_vld = 1'b1; bus.i_eop = 1'b1; tick();
      chk("rot_done", 32'({bus.o_done, bus.o_abort}), 32'b10);
      bus.i_vld = 1'b0; bus.i_eop = 1'b0;
    end
    mlast = 0;

    // Backpressure: no grant while the cache is not ready.
    bus.i_req = 16'h0010; bus.i_dst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_no_grant", 32'(bus.o_grant), 32'd0);
      chk("bp_ready", 32'(bus.o_port_ready), 32'd1);
    end
    bus.i_dst_ready = 1'b1;
    tick();
    chk("bp_grant", 32'(bus.o_grant), 32'h0010);
    bus.i_vld = 1'b1; bus.i_eop = 1'b1; tick();
    chk("bp_done", 32'({bus.o_done, bus.o_abort}), 32'b10);
    bus.i_vld = 1'b0; bus.i_eop = 1'b0;
    mlast = 4;

    // Skipping: park last_sel on port 5, then ports 0 and 3 alternate.
    model_pkt("park5", 16'h0020, 1, 1'b1, 0, 1'b0);
    model_pkt("skip_a", 16'h0009, 1, 1'b1, 0, 1'b0);
    model_pkt("skip_b", 16'h0009, 1, 1'b1, 0, 1'b0);
    model_pkt("skip_c", 16'h0009, 1, 1'b1, 0, 1'b0);
    chk("skip_last", 32'(mlast), 32'd0);

    // Timeout, maximal tolerated gap, and the MAXBEAT boundaries.
    model_pkt("timeout3", 16'h0002, 3, 1'b0, 0, 1'b0);
    model_pkt("gap_ok", 16'h0040, 2, 1'b1, TO - 1, 1'b0);
    model_pkt("ovl40", 16'h0080, 40, 1'b0, 0, 1'b0);
    model_pkt("ovl33eop", 16'h0080, 33, 1'b1, 0, 1'b0);
    model_pkt("max32eop", 16'h0080, 32, 1'b1, 0, 1'b0);

    // Reset during beat 5 drops the grant without any end pulse.
    bus.i_req = 16'h0F00;
    wait_grant(1'b0, port, ok);
    bus.i_vld = 1'b0; tick();
    for (int b = 1; b <= 4; b++) begin
      bus.i_vld = 1'b1; bus.i_eop = 1'b0; tick();
      chk("mid_no_pulse", 32'({bus.o_done, bus.o_abort}), 32'd0);
    end
    bus.i_vld = 1'b1; rst_n = 1'b0; tick();
    chk("mid_rst_grant", 32'(bus.o_grant), 32'd0);
    chk("mid_rst_pulses", 32'({bus.o_done, bus.o_abort}), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_port_ready), 32'd1);
    rst_n = 1'b1; bus.i_vld = 1'b0; mlast = PN - 1;
    model_pkt("after_rst", 16'hFFFF, 1, 1'b1, 0, 1'b0);

    // Randomized packets with random backpressure and request churn during transfers.
    for (int i = 0; i < 40; i++) begin
      model_pkt($sformatf("rnd%0d", i), 16'($urandom_range(1, 16'hFFFF)),
                $urandom_range(1, 36), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 2), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
